// File: rtl/decoder_pkg.sv
// Shared types and helpers for the decoder select sequencer.
// Pure declarations; no logic, no latency, no flow control.
package decoder_pkg;

    localparam int CODE_W = 3;
    localparam logic [CODE_W-1:0] CODE_MAX = 3'd7;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] HOLD = 2'd2;

    // Step the select code by one, wrapping modulo 8 in either direction.
    function automatic logic [CODE_W-1:0] next_code(input logic [CODE_W-1:0] code,
                                                    input logic              dir);
        return dir ? code - CODE_W'(1) : code + CODE_W'(1);
    endfunction

endpackage

// File: rtl/decoder_scan_ctrl_dwell_counter.sv
// Dwell timer: counts cycles a code has been held, flags the last cycle.
// Latency: tc is decoded from the registered count. No backpressure.
module dwell_counter #(
    parameter int DWELL = 100,
    parameter int CNT_W = 7
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign tc = (cnt == CNT_W'(DWELL - 1));

endmodule

// File: rtl/v3x8_decoder.sv
// 3-to-8 one-hot decoder; A is the select MSB.
// Combinational, zero latency, no backpressure.
module v3x8_decoder (
    input  logic       A,
    input  logic       B,
    input  logic       C,
    output logic [7:0] Y
);

    assign Y = 8'b1 << {A, B, C};

endmodule

// File: rtl/decoder_scan_ctrl.sv
// Sweeps the 3-bit decoder select through all codes with a programmable dwell.
// Start code one cycle after EN; advance every DWELL cycles. No backpressure.
module decoder_scan_ctrl
    import decoder_pkg::*;
#(
    parameter int DWELL = 100,
    parameter int CNT_W = 7
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              EN,
    input  logic              MODE,
    input  logic              DIR,
    input  logic              STEP,
    output logic              A,
    output logic              B,
    output logic              C,
    output logic [CODE_W-1:0] CODE,
    output logic              BUSY,
    output logic              DONE
);

    logic [1:0]        state;
    logic [CODE_W-1:0] code_q;
    logic              dir_q;
    logic              busy_q;
    logic              done_q;
    logic              cnt_clr;
    logic              cnt_en;
    logic              cnt_tc;
    logic              last_code;

    assign last_code = (code_q == (dir_q ? '0 : CODE_MAX));

    // Count freezes whenever EN drops in RUN, so the dwell resumes mid-way after HOLD.
    always_comb begin
        cnt_clr = 1'b0;
        cnt_en  = 1'b0;
        case (state)
            IDLE: cnt_clr = EN;
            RUN: begin
                cnt_clr = EN && cnt_tc;
                cnt_en  = EN && !cnt_tc;
            end
            HOLD: cnt_clr = !EN && STEP;
            default: cnt_clr = 1'b1;
        endcase
    end

    dwell_counter #(
        .DWELL (DWELL),
        .CNT_W (CNT_W)
    ) u_dwell (
        .clk (CLK),
        .rst (RST),
        .clr (cnt_clr),
        .en  (cnt_en),
        .tc  (cnt_tc)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state  <= IDLE;
            code_q <= '0;
            dir_q  <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (EN) begin
                        state  <= RUN;
                        busy_q <= 1'b1;
                        code_q <= DIR ? CODE_MAX : '0;
                        dir_q  <= DIR;
                    end else if (STEP) begin
                        code_q <= next_code(code_q, DIR);
                    end
                end
                RUN: begin
                    if (!EN) begin
                        state <= HOLD;
                    end else if (cnt_tc) begin
                        if (MODE && last_code) begin
                            state  <= IDLE;
                            busy_q <= 1'b0;
                            done_q <= 1'b1;
                        end else begin
                            code_q <= next_code(code_q, dir_q);
                        end
                    end
                end
                HOLD: begin
                    if (EN) begin
                        state <= RUN;
                    end else if (STEP) begin
                        code_q <= next_code(code_q, DIR);
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign CODE = code_q;
    assign A    = code_q[2];
    assign B    = code_q[1];
    assign C    = code_q[0];
    assign BUSY = busy_q;
    assign DONE = done_q;

endmodule

// File: tb/tb_decoder_scan_ctrl.sv
// Bench: two sequencers (dwell 4 and dwell 1) feeding 3-to-8 decoders, shared stimulus,
// compared every cycle against a behavioural model plus directed sweep/pause/step/reset checks.
module tb_decoder_scan_ctrl;

    logic       CLK = 1'b0;
    logic       RST, EN, MODE, DIR, STEP;
    logic       a0, b0, c0, busy0, done0;
    logic       a1, b1, c1, busy1, done1;
    logic [2:0] code0, code1;
    logic [7:0] y0, y1;

    int total = 0;
    int bad   = 0;

    int dwell [2] = '{4, 1};
    int m_st  [2];   // 0 idle, 1 run, 2 hold
    int m_code[2];
    int m_cnt [2];
    int m_dir [2];
    int m_done[2];

    always #5 CLK = ~CLK;

    decoder_scan_ctrl #(.DWELL(4), .CNT_W(7)) u_dut0 (
        .CLK(CLK), .RST(RST), .EN(EN), .MODE(MODE), .DIR(DIR), .STEP(STEP),
        .A(a0), .B(b0), .C(c0), .CODE(code0), .BUSY(busy0), .DONE(done0)
    );
    v3x8_decoder u_dec0 (.A(a0), .B(b0), .C(c0), .Y(y0));

    decoder_scan_ctrl #(.DWELL(1), .CNT_W(7)) u_dut1 (
        .CLK(CLK), .RST(RST), .EN(EN), .MODE(MODE), .DIR(DIR), .STEP(STEP),
        .A(a1), .B(b1), .C(c1), .CODE(code1), .BUSY(busy1), .DONE(done1)
    );
    v3x8_decoder u_dec1 (.A(a1), .B(b1), .C(c1), .Y(y1));

    task automatic check_eq(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int step_code(input int code, input int down);
        return (code + (down != 0 ? 7 : 1)) % 8;
    endfunction

    task automatic model_step();
        for (int i = 0; i < 2; i++) begin
            m_done[i] = 0;
            if (RST) begin
                m_st[i] = 0; m_code[i] = 0; m_cnt[i] = 0; m_dir[i] = 0;
            end else if (m_st[i] == 0) begin
                if (EN) begin
                    m_st[i] = 1; m_code[i] = DIR ? 7 : 0; m_dir[i] = DIR; m_cnt[i] = 0;
                end else if (STEP) begin
                    m_code[i] = step_code(m_code[i], DIR);
                end
            end else if (m_st[i] == 1) begin
                if (!EN) begin
                    m_st[i] = 2;
                end else if (m_cnt[i] + 1 == dwell[i]) begin
                    m_cnt[i] = 0;
                    if (MODE && m_code[i] == (m_dir[i] != 0 ? 0 : 7)) begin
                        m_st[i] = 0; m_done[i] = 1;
                    end else begin
                        m_code[i] = step_code(m_code[i], m_dir[i]);
                    end
                end else begin
                    m_cnt[i]++;
                end
            end else begin
                if (EN) begin
                    m_st[i] = 1;
                end else if (STEP) begin
                    m_code[i] = step_code(m_code[i], DIR); m_cnt[i] = 0;
                end
            end
        end
    endtask

    task automatic check_all();
        check_eq("code0", int'(code0), m_code[0]);
        check_eq("abc0", int'({a0, b0, c0}), m_code[0]);
        check_eq("y0", int'(y0), 1 << m_code[0]);
        check_eq("busy0", int'(busy0), int'(m_st[0] != 0));
        check_eq("done0", int'(done0), m_done[0]);
        check_eq("code1", int'(code1), m_code[1]);
        check_eq("abc1", int'({a1, b1, c1}), m_code[1]);
        check_eq("y1", int'(y1), 1 << m_code[1]);
        check_eq("busy1", int'(busy1), int'(m_st[1] != 0));
        check_eq("done1", int'(done1), m_done[1]);
    endtask

    task automatic tick();
        @(posedge CLK);
        model_step();
        #1;
        check_all();
    endtask

    task automatic do_reset();
        RST = 1'b1; EN = 1'b0; MODE = 1'b0; DIR = 1'b0; STEP = 1'b0;
        tick(); tick();
        RST = 1'b0;
    endtask

    initial begin
        int n;
        int saw_done;

        for (int i = 0; i < 2; i++) begin
            m_st[i] = 0; m_code[i] = 0; m_cnt[i] = 0; m_dir[i] = 0; m_done[i] = 0;
        end

        // Reset values
        do_reset();
        check_eq("rst_code", int'(code0), 0);
        check_eq("rst_busy", int'(busy0), 0);
        check_eq("rst_done", int'(done0), 0);

        // Continuous up sweep, dwell 4: 0..7,0,1 each held 4 cycles
        EN = 1'b1; MODE = 1'b0; DIR = 1'b0;
        saw_done = 0;
        for (int k = 0; k < 40; k++) begin
            tick();
            check_eq("cont_seq", int'(code0), (k / 4) % 8);
            check_eq("cont_busy", int'(busy0), 1);
            if (done0) saw_done = 1;
        end
        check_eq("cont_no_done", saw_done, 0);

        // One-shot down sweep: DONE 32 cycles after start, then IDLE at code 0
        do_reset();
        EN = 1'b1; MODE = 1'b1; DIR = 1'b1;
        tick();
        check_eq("os_start", int'(code0), 7);
        n = 1;
        while (!done0 && n < 100) begin
            tick();
            n++;
        end
        check_eq("os_done_edge", n, 33);
        check_eq("os_end_code", int'(code0), 0);
        check_eq("os_end_busy", int'(busy0), 0);
        EN = 1'b0;
        tick();
        check_eq("os_done_pulse", int'(done0), 0);

        // Pause at code 3 mid-dwell, resume
        do_reset();
        EN = 1'b1; MODE = 1'b0; DIR = 1'b0;
        n = 0;
        while (!(m_st[0] == 1 && m_code[0] == 3 && m_cnt[0] == 2) && n < 100) begin
            tick();
            n++;
        end
        check_eq("pause_reach", int'(n < 100), 1);
        EN = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick();
            check_eq("pause_hold", int'(code0), 3);
        end
        EN = 1'b1;
        tick();
        n = 0;
        while (code0 != 3'd4 && n < 20) begin
            tick();
            n++;
        end
        check_eq("resume_lat", n, 2);

        // Single step in IDLE
        do_reset();
        DIR = 1'b1; STEP = 1'b1; tick(); STEP = 1'b0; tick();
        check_eq("step_to7", int'(code0), 7);
        DIR = 1'b0; STEP = 1'b1; tick(); STEP = 1'b0; tick();
        check_eq("step_wrap0", int'(code0), 0);
        DIR = 1'b1; STEP = 1'b1; tick();
        check_eq("step_down7", int'(code0), 7);
        tick();
        check_eq("step_down6", int'(code0), 6);
        check_eq("step_busy", int'(busy0), 0);
        STEP = 1'b0;

        // Reset mid-run at code 5 overrides EN and STEP
        EN = 1'b1; DIR = 1'b0; MODE = 1'b0;
        n = 0;
        while (code0 != 3'd5 && n < 100) begin
            tick();
            n++;
        end
        RST = 1'b1; STEP = 1'b1;
        tick();
        check_eq("midrst_code", int'(code0), 0);
        check_eq("midrst_busy", int'(busy0), 0);
        check_eq("midrst_done", int'(done0), 0);
        RST = 1'b0; EN = 1'b0; STEP = 1'b0;
        tick();
        check_eq("midrst_idle", int'(busy0), 0);

        // Dwell 1: decoder output walks one bit per cycle
        do_reset();
        EN = 1'b1; MODE = 1'b0; DIR = 1'b0;
        for (int k = 0; k < 9; k++) begin
            tick();
            check_eq("walk_y", int'(y1), 1 << (k % 8));
        end

        // Randomised traffic against the model
        do_reset();
        for (int k = 0; k < 3000; k++) begin
            RST  = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 15) == 0) EN = ~EN;
            if ($urandom_range(0, 31) == 0) MODE = $urandom_range(0, 1) != 0;
            if ($urandom_range(0, 7) == 0) DIR = $urandom_range(0, 1) != 0;
            STEP = ($urandom_range(0, 3) == 0);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
